sbox_share_scheduler: RTL and testbench
=======================================

Name: sbox_share_scheduler

Overview:
Time-multiplexes a small pool of combinational byte S-box units (N_SBOX lanes) between two requesters. The requesters are the round datapath (SubBytes on a 128-bit state) and the key expansion (SubWord on a 32-bit word). The block arbitrates round-robin, slices the captured operand into N_SBOX-byte chunks, drives the shared S-box lanes one chunk per cycle, and reassembles the result. It sits between the round controller/key scheduler and the instantiated byte_substitution lanes, which are built with no output register.

Parameters:
NB_BYTE, 8, bits per byte; only 8 is supported.
N_SBOX, 4, shared S-box lanes; legal values are 1, 2 and 4; any other value raises BAD_CONF.
NB_STATE, 128, state width; fixed at 16 bytes.
NB_WORD, 32, key word width; fixed at 4 bytes.

Ports:
i_clock  in  1  single clock; all state updates on posedge.
i_reset  in  1  asynchronous, active-high reset.
i_state_valid  in  1  SubBytes request.
i_state  in  NB_STATE  state operand; byte j = bits [8j+7:8j].
o_state_ready  out  1  state request granted this cycle.
o_state_done  out  1  one-cycle pulse: o_state_sub is valid.
o_state_sub  out  NB_STATE  substituted state; held until the next state job completes.
i_word_valid  in  1  SubWord request.
i_word  in  NB_WORD  word operand; same byte order as i_state.
o_word_ready  out  1  word request granted this cycle.
o_word_done  out  1  one-cycle pulse: o_word_sub is valid.
o_word_sub  out  NB_WORD  substituted word; held until the next word job completes.
o_sbox_bytes  out  N_SBOX*NB_BYTE  bytes to the S-box lanes; lane l = bits [8l+7:8l].
i_sbox_bytes  in  N_SBOX*NB_BYTE  same-cycle lane results from the combinational S-boxes.
o_busy  out  1  high in every state except IDLE.

Behaviour:
- FSM states:
  - IDLE → RUN_STATE or RUN_WORD on an accepted handshake.
  - RUN_* → DONE after the last chunk.
  - DONE → IDLE unconditionally.
- Arbitration is combinational, and only in IDLE:
  - grant_state = i_state_valid & (!i_word_valid | last_grant==WORD).
  - grant_word = i_word_valid & (!i_state_valid | last_grant==STATE).
  - o_state_ready = IDLE & grant_state; o_word_ready = IDLE & grant_word.
  - At most one ready is ever high. Ready may depend on valid, so requesters must not wait for ready before asserting valid.
- Accept = valid & ready, at edge T:
  - The operand is captured into an internal register; input changes after T are ignored.
  - last_grant is updated; chunk counter is cleared.
- RUN phase:
  - Runs in cycles T+1 … T+K, where K = 16/N_SBOX (state) or 4/N_SBOX (word).
  - In cycle c, o_sbox_bytes lane l = captured byte c*N_SBOX+l.
  - i_sbox_bytes lane l is written at the closing edge into result byte c*N_SBOX+l.
  - The counter wraps to 0 after chunk K-1, and the FSM moves to DONE.
- DONE, cycle T+K+1:
  - The matching o_*_done is high for exactly one cycle and o_*_sub is complete.
  - No ready is asserted in DONE; the next accept is possible in cycle T+K+2.
  - Per-job occupancy is K+2 cycles: N_SBOX=4 gives 6 cycles (state) and 3 cycles (word).
- o_*_sub is written only by its own job type. Partial bytes update an internal shadow; the output register loads on transition to DONE, so o_*_sub never shows a partially substituted value.
- o_sbox_bytes = 0 in IDLE and DONE.
- Reset values:
  - state = IDLE, last_grant = STATE (the first tie after reset goes to WORD), counter = 0.
  - o_state_sub = 0, o_word_sub = 0, both done = 0, o_busy = 0, both ready = 0 while reset is asserted.
- Reset mid-job: the job is dropped silently, no done pulse is emitted, and outputs return to their reset values immediately (asynchronously).
- A valid deasserted before ready has no effect; no request is queued.
- With both valids held continuously, grants alternate WORD, STATE, WORD, …

Test Plan:
- Reset, then word request only, i_word=32'h0000_0053, N_SBOX=4 → o_word_ready at T; o_sbox_bytes=32'h0000_0053 in T+1; o_word_done in T+2 with o_word_sub=32'h6363_63ED.
- State request only, i_state bytes 0x00..0x0F (byte0=0x00), N_SBOX=4:
  - Chunks 0..3 are driven in T+1..T+4.
  - o_state_done at T+5 with byte0..3 = 63 7C 77 7B and byte15 = 0x76.
  - o_busy is high T+1..T+5.
- Both valids held from reset → grants go WORD first, then STATE, then WORD; ready is never high for both; no ready is asserted in DONE cycles.
- Assert i_reset during chunk 2 of a state job → all outputs return to 0 immediately, no o_state_done; the next state job produces the correct result.
- N_SBOX=1, state job → 16 chunk cycles, done at T+17. Changing i_state after T does not alter o_state_sub.
- Back-to-back: a word job completes while a state job is pending → o_word_sub is held unchanged throughout the state job.

Source files
------------

// File: rtl/sbox_share_scheduler.sv
// Round-robin sharing of N_SBOX combinational S-box lanes between SubBytes (128-bit state)
// and SubWord (32-bit key word) jobs; one N_SBOX-byte chunk is substituted per cycle.
module sbox_share_scheduler #(
   parameter int NB_BYTE  = 8,
   parameter int N_SBOX   = 4,
   parameter int NB_STATE = 128,
   parameter int NB_WORD  = 32
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic                      i_state_valid,
   input  logic [NB_STATE-1:0]       i_state,
   output logic                      o_state_ready,
   output logic                      o_state_done,
   output logic [NB_STATE-1:0]       o_state_sub,
   input  logic                      i_word_valid,
   input  logic [NB_WORD-1:0]        i_word,
   output logic                      o_word_ready,
   output logic                      o_word_done,
   output logic [NB_WORD-1:0]        o_word_sub,
   output logic [N_SBOX*NB_BYTE-1:0] o_sbox_bytes,
   input  logic [N_SBOX*NB_BYTE-1:0] i_sbox_bytes,
   output logic                      o_busy
);
   localparam int LANE_W  = N_SBOX * NB_BYTE;
   localparam int K_STATE = NB_STATE / LANE_W;
   localparam int K_WORD  = NB_WORD / LANE_W;
   localparam logic [3:0] LAST_STATE = 4'(K_STATE - 1);
   localparam logic [3:0] LAST_WORD  = 4'(K_WORD - 1);

   if (NB_BYTE != 8 || NB_STATE != 128 || NB_WORD != 32 ||
       !(N_SBOX == 1 || N_SBOX == 2 || N_SBOX == 4)) begin : g_bad_conf
      $error("BAD_CONF: unsupported sbox_share_scheduler parameter set");
   end

   typedef enum logic [1:0] {IDLE, RUN_STATE, RUN_WORD, DONE} fsm_t;

   fsm_t                fsm_q;
   logic                last_word_q;
   logic [3:0]          cnt_q;
   logic [NB_STATE-1:0] op_q;
   logic [NB_STATE-1:0] shadow_q;
   logic [NB_STATE-1:0] shadow_d;
   logic [NB_STATE-1:0] state_sub_q;
   logic [NB_WORD-1:0]  word_sub_q;
   logic                state_done_q;
   logic                word_done_q;
   logic                grant_state;
   logic                grant_word;

   // Tie-break favours whichever requester was not served last.
   assign grant_state = i_state_valid & (~i_word_valid | last_word_q);
   assign grant_word  = i_word_valid & (~i_state_valid | ~last_word_q);

   // Ready is gated by reset so it stays low while reset is held, even with valids high.
   assign o_state_ready = ~i_reset & (fsm_q == IDLE) & grant_state;
   assign o_word_ready  = ~i_reset & (fsm_q == IDLE) & grant_word;

   // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
   always_comb begin
      shadow_d = shadow_q;
      shadow_d[int'(cnt_q)*LANE_W +: LANE_W] = i_sbox_bytes;
   end

   always_comb begin
      o_sbox_bytes = '0;
      if (fsm_q == RUN_STATE || fsm_q == RUN_WORD) begin
         o_sbox_bytes = op_q[int'(cnt_q)*LANE_W +: LANE_W];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         fsm_q        <= IDLE;
         last_word_q  <= 1'b0;
         cnt_q        <= '0;
         op_q         <= '0;
         shadow_q     <= '0;
         state_sub_q  <= '0;
         word_sub_q   <= '0;
         state_done_q <= 1'b0;
         word_done_q  <= 1'b0;
      end else begin
         state_done_q <= 1'b0;
         word_done_q  <= 1'b0;
         case (fsm_q)
            IDLE: begin
               if (o_state_ready) begin
                  op_q        <= i_state;
                  last_word_q <= 1'b0;
                  cnt_q       <= '0;
                  fsm_q       <= RUN_STATE;
               end else if (o_word_ready) begin
                  op_q        <= NB_STATE'(i_word);
                  last_word_q <= 1'b1;
                  cnt_q       <= '0;
                  fsm_q       <= RUN_WORD;
               end
            end
            RUN_STATE: begin
               shadow_q <= shadow_d;
               if (cnt_q == LAST_STATE) begin
                  cnt_q        <= '0;
                  state_sub_q  <= shadow_d;
                  state_done_q <= 1'b1;
                  fsm_q        <= DONE;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            RUN_WORD: begin
               shadow_q <= shadow_d;
               if (cnt_q == LAST_WORD) begin
                  cnt_q       <= '0;
                  word_sub_q  <= shadow_d[NB_WORD-1:0];
                  word_done_q <= 1'b1;
                  fsm_q       <= DONE;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

   assign o_state_done = state_done_q;
   assign o_word_done  = word_done_q;
   assign o_state_sub  = state_sub_q;
   assign o_word_sub   = word_sub_q;
   assign o_busy       = (fsm_q != IDLE);
endmodule

// File: tb/tb_sbox_share_scheduler.sv
// Self-checking bench: AES S-box lanes modelled from GF(2^8) arithmetic, jobs checked
// chunk by chunk against a byte-wise reference and a round-robin grant model.
module tb_sbox_share_scheduler;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         sv, sr, sd, wv, wr, wdone, busy;
   logic [127:0] st, ss;
   logic [31:0]  wd, wsub, sbo, sbi;
   logic         sv1, sr1, sd1, wv1, wr1, wdone1, busy1;
   logic [127:0] st1, ss1;
   logic [31:0]  wd1, wsub1;
   logic [7:0]   sbo1, sbi1;

   logic [7:0] sbox_tab [256];
   int         n_cmp = 0;
   int         n_bad = 0;
   logic       last_word_m;

   sbox_share_scheduler #(.N_SBOX(4)) dut4 (
      .i_clock(clk), .i_reset(rst),
      .i_state_valid(sv), .i_state(st), .o_state_ready(sr), .o_state_done(sd), .o_state_sub(ss),
      .i_word_valid(wv), .i_word(wd), .o_word_ready(wr), .o_word_done(wdone), .o_word_sub(wsub),
      .o_sbox_bytes(sbo), .i_sbox_bytes(sbi), .o_busy(busy));

   sbox_share_scheduler #(.N_SBOX(1)) dut1 (
      .i_clock(clk), .i_reset(rst),
      .i_state_valid(sv1), .i_state(st1), .o_state_ready(sr1), .o_state_done(sd1), .o_state_sub(ss1),
      .i_word_valid(wv1), .i_word(wd1), .o_word_ready(wr1), .o_word_done(wdone1), .o_word_sub(wsub1),
      .o_sbox_bytes(sbo1), .i_sbox_bytes(sbi1), .o_busy(busy1));

   always_comb begin
      sbi = '0;
      for (int l = 0; l < 4; l++) sbi[l*8 +: 8] = sbox_tab[sbo[l*8 +: 8]];
   end
   always_comb sbi1 = sbox_tab[sbo1];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = '0;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
      return (b << k) | (b >> (8 - k));
   endfunction

   task automatic init_tab();
      for (int v = 0; v < 256; v++) begin
         logic [7:0] inv = 8'd1;
         for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(v));
         sbox_tab[v] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] sub_bytes(input logic [127:0] x, input int nbytes);
      logic [127:0] r = '0;
      for (int i = 0; i < nbytes; i++) r[i*8 +: 8] = sbox_tab[x[i*8 +: 8]];
      return r;
   endfunction

   function automatic logic exp_grant_word(input logic s, input logic w, input logic last_w);
      return w && (!s || !last_w);
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with requests already driven; leaves the bench at cycle T+K+2.
   task automatic run4(input logic exp_word, input bit drop);
      logic [127:0] op, other, got;
      int           k;
      #1;
      check("ready_word", wr, exp_word);
      check("ready_state", sr, !exp_word);
      check("busy_at_accept", busy, 0);
      op    = exp_word ? 128'(wd) : st;
      k     = exp_word ? 1 : 4;
      other = exp_word ? ss : 128'(wsub);
      last_word_m = exp_word;
      @(negedge clk);
      st = rand128();
      wd = $urandom;
      if (drop) begin
         sv = 1'b0;
         wv = 1'b0;
      end
      #1;
      for (int c = 0; c < k; c++) begin
         check("chunk_bytes", sbo, op[c*32 +: 32]);
         check("busy_run", busy, 1);
         check("no_ready_run", {sr, wr}, 0);
         check("no_done_run", {sd, wdone}, 0);
         @(negedge clk);
         #1;
      end
      check("done_pulse", {sd, wdone}, exp_word ? 2'b01 : 2'b10);
      got = exp_word ? 128'(wsub) : ss;
      check("sub_result", got, sub_bytes(op, exp_word ? 4 : 16));
      check("other_sub_held", exp_word ? ss : 128'(wsub), other);
      check("no_ready_done", {sr, wr}, 0);
      check("lanes_zero_done", sbo, 0);
      check("busy_done", busy, 1);
      @(negedge clk);
      #1;
      check("done_cleared", {sd, wdone}, 0);
      check("busy_after", busy, 0);
   endtask

   initial begin
      logic [127:0] op1;
      init_tab();
      rst = 1'b1;
      sv = 1'b1; wv = 1'b1; st = rand128(); wd = $urandom;
      sv1 = 1'b0; wv1 = 1'b0; st1 = '0; wd1 = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_ready", {sr, wr, sr1, wr1}, 0);
      check("rst_busy", {busy, busy1}, 0);
      check("rst_done", {sd, wdone, sd1, wdone1}, 0);
      check("rst_state_sub", ss, 0);
      check("rst_word_sub", wsub, 0);
      check("rst_lanes", sbo, 0);
      sv = 1'b0; wv = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      last_word_m = 1'b0;
      @(negedge clk);

      wd = 32'h0000_0053; wv = 1'b1;
      run4(1'b1, 1'b1);
      check("word_0x53_const", wsub, 128'h6363_63ED);

      for (int i = 0; i < 16; i++) st[i*8 +: 8] = 8'(i);
      sv = 1'b1;
      run4(exp_grant_word(1'b1, 1'b0, last_word_m), 1'b1);
      check("state_b0_3_const", ss[31:0], 32'h7B77_7C63);
      check("state_b15_const", ss[127:120], 8'h76);

      for (int i = 0; i < 10; i++) begin
         sv = 1'($urandom_range(0, 1));
         wv = 1'($urandom_range(0, 1));
         if (!sv && !wv) wv = 1'b1;
         st = rand128();
         wd = $urandom;
         run4(exp_grant_word(sv, wv, last_word_m), 1'b1);
      end

      rst = 1'b1;
      #1;
      check("rst2_subs", {ss, 32'(wsub)} == '0, 1);
      sv = 1'b1; wv = 1'b1; st = rand128(); wd = $urandom;
      @(negedge clk);
      rst = 1'b0;
      last_word_m = 1'b0;
      for (int j = 0; j < 6; j++) run4(exp_grant_word(1'b1, 1'b1, last_word_m), 1'b0);
      sv = 1'b0; wv = 1'b0;
      @(negedge clk);

      sv = 1'b1; st = rand128();
      op1 = st;
      #1;
      check("mid_ready", sr, 1);
      @(negedge clk);
      sv = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("mid_chunk2", sbo, op1[95:64]);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_lanes", sbo, 0);
      check("mid_rst_state_sub", ss, 0);
      check("mid_rst_word_sub", wsub, 0);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         #1;
         check("mid_rst_no_done", {sd, wdone}, 0);
      end
      rst = 1'b0;
      last_word_m = 1'b0;
      @(negedge clk);
      sv = 1'b1; st = rand128();
      run4(1'b0, 1'b1);

      sv1 = 1'b1; st1 = rand128();
      op1 = st1;
      #1;
      check("n1_ready", sr1, 1);
      @(negedge clk);
      sv1 = 1'b0; st1 = rand128();
      #1;
      for (int c = 0; c < 16; c++) begin
         check("n1_chunk", sbo1, op1[c*8 +: 8]);
         check("n1_no_done", sd1, 0);
         @(negedge clk);
         #1;
      end
      check("n1_done", sd1, 1);
      check("n1_sub", ss1, sub_bytes(op1, 16));
      check("n1_word_done_quiet", wdone1, 0);
      @(negedge clk);
      #1;
      check("n1_done_cleared", sd1, 0);
      check("n1_sub_held", ss1, sub_bytes(op1, 16));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
